// File: rtl/axis_reset_sequencer.sv
// Initiator side of the FIFO reset handshake. It drives registered reset pulses to the
// downstream adapters, waits for their rst_busy lines to clear, and enforces a holdoff.
module axis_reset_sequencer #(
  parameter int NUM_BUSY  = 1,
  parameter int PULSE_LEN = 2,
  parameter int HOLDOFF   = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rst_req_i,
  input  logic                graceful_i,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic [NUM_BUSY-1:0] busy_i,
  output logic                m_aresetn_o,
  output logic                hold_o,
  output logic                ready_o,
  output logic                done_o,
  output logic                timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ASSERT,
    S_WAIT_BUSY,
    S_HOLDOFF
  } state_e;

  localparam logic [15:0] PULSE_LAST   = 16'(PULSE_LEN - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLDOFF - 1);
  localparam logic [15:0] HOLD_PRE     = 16'(HOLDOFF - 2);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_packet_q, in_packet_d;
  logic        pending_q, pending_d;
  logic        timeout_q, timeout_d;
  logic        m_aresetn_q, hold_q, ready_q, done_q;
  logic        m_aresetn_d, hold_d, ready_d, done_d;
  logic        hs;
  logic        busy_clear;

  // The stream is only monitored: a beat transfers in any cycle with tvalid && tready.
  assign hs         = s_axis_tvalid && s_axis_tready;
  assign busy_clear = ~|busy_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    in_packet_d = hs ? !s_axis_tlast : in_packet_q;
    pending_d   = (state_q == S_IDLE) ? 1'b0 : (pending_q || rst_req_i);

    case (state_q)
      S_IDLE: begin
        if (rst_req_i || pending_q) begin
          cnt_d   = 16'd0;
          // Drain only if a packet is still open after this cycle's beat.
          state_d = (graceful_i && in_packet_d) ? S_DRAIN : S_ASSERT;
        end
      end
      S_DRAIN: begin
        if (hs && s_axis_tlast) begin
          state_d = S_ASSERT;
          cnt_d   = 16'd0;
        end
      end
      S_ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_BUSY;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_BUSY: begin
        if (busy_clear) begin
          state_d = S_HOLDOFF;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_HOLDOFF;
          cnt_d     = 16'd0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLDOFF: begin
        // done_o is registered, so it is raised one count early to land on the exit cycle.
        done_d = (cnt_q == HOLD_PRE);
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_ASSERT;
        cnt_d   = 16'd0;
      end
    endcase

    if (state_d == S_ASSERT && state_q != S_ASSERT) begin
      in_packet_d = 1'b0;
    end

    m_aresetn_d = (state_d != S_ASSERT);
    hold_d      = (state_d != S_IDLE);
    ready_d     = (state_d == S_IDLE) && !pending_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_ASSERT;
      cnt_q       <= 16'd0;
      in_packet_q <= 1'b0;
      pending_q   <= 1'b0;
      timeout_q   <= 1'b0;
      m_aresetn_q <= 1'b0;
      hold_q      <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_packet_q <= in_packet_d;
      pending_q   <= pending_d;
      timeout_q   <= timeout_d;
      m_aresetn_q <= m_aresetn_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign m_aresetn_o = m_aresetn_q;
  assign hold_o      = hold_q;
  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_axis_reset_sequencer.sv
// Randomized bench for axis_reset_sequencer against a timestamp-based model of each
// reset sequence (pulse start, busy-clear cycle, holdoff end).
module tb_axis_reset_sequencer;

  localparam int NB = 2;
  localparam int PL = 2;
  localparam int HO = 8;
  localparam int TO = 20;
  localparam int NUM_CYCLES = 5000;

  // clock / reset
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          aresetn;
  logic          rst_req, graceful, tvalid, tready, tlast;
  logic [NB-1:0] busy;
  logic          m_aresetn, hold, ready, done, timeout;

  axis_reset_sequencer #(
    .NUM_BUSY (NB),
    .PULSE_LEN(PL),
    .HOLDOFF  (HO),
    .TIMEOUT  (TO)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .rst_req_i    (rst_req),
    .graceful_i   (graceful),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .busy_i       (busy),
    .m_aresetn_o  (m_aresetn),
    .hold_o       (hold),
    .ready_o      (ready),
    .done_o       (done),
    .timeout_o    (timeout)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", tag, cyc, act, exp);
    end
  endtask

  // Model: mode 0 = idle, 1 = draining, 2 = sequence running.
  // t0 = first low cycle of the pulse, tw = cycle the busy wait ended (-1 = not yet).
  int   mode = 2;
  int   t0   = 0;
  int   tw   = -1;
  bit   pend = 1'b0;
  bit   inpkt = 1'b0;
  bit   tmo  = 1'b0;
  logic exp_m, exp_hold, exp_ready, exp_done;

  task automatic model_step();
    bit hs, nxt;
    hs = tvalid && tready;
    if (!aresetn) begin
      mode = 2; t0 = cyc + 1; tw = -1; pend = 0; inpkt = 0; tmo = 0;
    end else begin
      nxt = hs ? !tlast : inpkt;
      case (mode)
        0: begin
          if (rst_req || pend) begin
            pend = 0;
            if (graceful && nxt) mode = 1;
            else begin mode = 2; t0 = cyc + 1; tw = -1; nxt = 0; end
          end
        end
        1: begin
          if (rst_req) pend = 1;
          if (hs && tlast) begin mode = 2; t0 = cyc + 1; tw = -1; nxt = 0; end
        end
        default: begin
          if (rst_req) pend = 1;
          if (tw < 0 && cyc >= t0 + PL) begin
            if (busy == '0) tw = cyc;
            else if (cyc == t0 + PL + TO - 1) begin tw = cyc; tmo = 1; end
          end else if (tw >= 0 && cyc == tw + HO) begin
            mode = 0;
          end
        end
      endcase
      inpkt = nxt;
    end
  endtask

  // driver state
  int busy_cnt  = 0;
  int rst_left  = 0;
  bit drop_drain_done  = 0;
  bit drop_assert_done = 0;
  int pulses = 0;

  initial begin
    bit was_high, trigger, stuck;
    aresetn = 1'b0; rst_req = 0; graceful = 0; tvalid = 0; tready = 0; tlast = 0; busy = '0;

    while (cyc < NUM_CYCLES) begin
      @(posedge aclk); #1;
      exp_m     = !(mode == 2 && cyc >= t0 && cyc < t0 + PL);
      exp_hold  = (mode != 0);
      exp_ready = (mode == 0) && !pend;
      exp_done  = (mode == 2) && (tw >= 0) && (cyc == tw + HO);
      check_eq("m_aresetn", m_aresetn, exp_m);
      check_eq("hold",      hold,      exp_hold);
      check_eq("ready",     ready,     exp_ready);
      check_eq("done",      done,      exp_done);
      check_eq("timeout",   timeout,   tmo);
      if (mode == 2 && cyc == t0) pulses++;

      // reset drive, including directed drops mid-DRAIN and mid-ASSERT
      was_high = aresetn;
      if (cyc < 3) begin
        aresetn = 1'b0;
      end else if (rst_left > 0) begin
        aresetn = 1'b0;
        rst_left--;
      end else begin
        trigger = 0;
        if (cyc >= 3400 && !drop_drain_done && mode == 1) begin
          trigger = 1; drop_drain_done = 1;
        end else if (cyc >= 3400 && !drop_assert_done && mode == 2 && cyc == t0 && was_high) begin
          trigger = 1; drop_assert_done = 1;
        end else if (cyc >= 3400 && $urandom_range(0, 399) == 0) begin
          trigger = 1;
        end
        if (trigger) begin
          aresetn  = 1'b0;
          rst_left = $urandom_range(0, 2);
        end else begin
          aresetn = 1'b1;
        end
      end
      if (was_high && !aresetn) begin
        #1;
        check_eq("rst_m_aresetn", m_aresetn, 1'b0);
        check_eq("rst_hold",      hold,      1'b1);
        check_eq("rst_ready",     ready,     1'b0);
        check_eq("rst_done",      done,      1'b0);
        check_eq("rst_timeout",   timeout,   1'b0);
      end

      // control and stream stimulus
      stuck    = (cyc >= 3000 && cyc < 3400);
      rst_req  = stuck ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 11) == 0);
      graceful = $urandom_range(0, 1) == 1;
      tvalid   = $urandom_range(0, 1) == 1;
      tready   = $urandom_range(0, 3) != 0;
      tlast    = $urandom_range(0, 3) == 0;

      // busy follows each pulse for a random time, with occasional stray glitches
      if (!exp_m) busy_cnt = $urandom_range(0, 10);
      if (stuck) busy = 2'b10;
      else if (busy_cnt > 0) busy = 2'($urandom_range(1, 3));
      else busy = ($urandom_range(0, 29) == 0) ? 2'b01 : 2'b00;
      if (busy_cnt > 0 && exp_m) busy_cnt--;

      model_step();
      cyc++;
    end

    $display("sequences started: %0d, drain drop %0d, assert drop %0d", pulses, drop_drain_done, drop_assert_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
